mem_stage_ctrl: RTL and testbench

- Consumer end of the EXE/MEM pipeline register in the RISC core.
- Takes the registered EXE bundle and performs any load/store or I/O access over the 8-bit system bus using a req/ack handshake; 16-bit accesses are split into two byte cycles.
- Drives `stall` back to the EXE latch and earlier stages while an access is in flight.
- Registers the MEM/WB bundle for the write-back stage.

---
 rtl/core_pkg.sv | 31 +++
 rtl/mem_wb_latch.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RISC core pipeline: MEMctrl bit positions,
// MEM-stage FSM encoding and the MEM/WB bundle layout.
package core_pkg;

  // MEMctrl field bit positions (bits 6:5 are reserved)
  localparam int MC_RD     = 0;
  localparam int MC_WR     = 1;
  localparam int MC_IO     = 2;
  localparam int MC_WORD   = 3;
  localparam int MC_SELNPC = 4;

  // Value returned for a byte whose bus cycle timed out
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_e;

  // MEM/WB bundle handed to write-back
  typedef struct packed {
    logic [4:0]  wr_id;
    logic [7:0]  fmask;
    logic [7:0]  flags;
    logic [15:0] data;
    logic        eoi;
  } wb_t;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: loads the presented bundle when ld=1,
// otherwise captures an all-zero bubble.
module mem_wb_latch
  import core_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic ld,
  input  wb_t  d,
  output wb_t  q
);

  wb_t wb_d, wb_q;

  // Select between the new bundle and a bubble
  always_comb begin
    wb_d = '0;
    if (ld) wb_d = d;
  end

  // Register with synchronous reset to a bubble
  always_ff @(posedge CLK) begin
    if (RST) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  assign q = wb_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: sequences loads/stores/I-O over the 8-bit req/ack
// bus (words as two byte cycles), stalls upstream while busy and feeds the
// MEM/WB register. Upstream holds the EXE bundle stable while stall=1, so
// the inputs are used directly throughout an access.
module mem_stage_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = 64
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  Wr_id_in,
  input  logic [7:0]  Fmask_in,
  input  logic [6:0]  MEMctrl_in,
  input  logic [7:0]  Flags_in,
  input  logic [15:0] Result_in,
  input  logic [15:0] Src1_in,
  input  logic [15:0] seqNPC_in,
  input  logic        EOI_in,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        bus_err,
  output logic [4:0]  Wr_id_out,
  output logic [15:0] Wr_data_out,
  output logic [7:0]  Fmask_out,
  output logic [7:0]  Flags_out,
  output logic        EOI_out
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_io_q, mem_io_d;
  logic          bus_err_q, bus_err_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic [7:0]    lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          wb_ld;
  wb_t           wb_nxt, wb_out;

  logic          op_rd, op_wr, op_io, op_word, op_npc, memop;
  logic          ack_v, tmo, byte_done;
  logic [7:0]    rbyte;
  logic          unused_rsvd;

  assign op_rd   = MEMctrl_in[MC_RD];
  assign op_wr   = MEMctrl_in[MC_WR];
  assign op_io   = MEMctrl_in[MC_IO];
  assign op_word = MEMctrl_in[MC_WORD];
  assign op_npc  = MEMctrl_in[MC_SELNPC];
  assign memop   = op_rd | op_wr;
  assign unused_rsvd = ^MEMctrl_in[6:5];

  // An ack only counts while a request is outstanding; a timeout behaves as
  // an ack carrying open-bus data.
  assign ack_v     = mem_req_q & mem_ack;
  assign tmo       = mem_req_q & ~mem_ack & (cnt_q == CW'(TIMEOUT - 1));
  assign byte_done = ack_v | tmo;
  assign rbyte     = ack_v ? mem_rdata : OPEN_BUS;

  assign stall = ((state_q == IDLE) & memop) | (state_q == ACC_LO) | (state_q == ACC_HI);

  // Next-state, bus sequencing and write-back selection
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_io_d      = mem_io_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    bus_err_d     = 1'b0;
    lo_d          = lo_q;
    cnt_d         = cnt_q;
    wb_ld         = 1'b0;
    wb_nxt.wr_id  = Wr_id_in;
    wb_nxt.fmask  = Fmask_in;
    wb_nxt.flags  = Flags_in;
    wb_nxt.eoi    = EOI_in;
    wb_nxt.data   = Result_in;

    case (state_q)
      IDLE: begin
        if (memop) begin
          state_d     = ACC_LO;
          mem_req_d   = 1'b1;
          mem_addr_d  = Result_in;
          mem_we_d    = op_wr & ~op_rd;
          mem_io_d    = op_io;
          mem_wdata_d = Src1_in[7:0];
          cnt_d       = '0;
        end else begin
          wb_ld       = 1'b1;
          wb_nxt.data = op_npc ? seqNPC_in : Result_in;
        end
      end
      ACC_LO: begin
        if (byte_done) begin
          bus_err_d = tmo;
          lo_d      = rbyte;
          if (op_word) begin
            state_d     = ACC_HI;
            mem_addr_d  = mem_addr_q + 16'd1;
            mem_wdata_d = Src1_in[15:8];
            cnt_d       = '0;
          end else begin
            state_d     = DONE;
            mem_req_d   = 1'b0;
            wb_ld       = 1'b1;
            wb_nxt.data = op_rd ? {8'h00, rbyte} : Result_in;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACC_HI: begin
        if (byte_done) begin
          bus_err_d   = tmo;
          state_d     = DONE;
          mem_req_d   = 1'b0;
          wb_ld       = 1'b1;
          wb_nxt.data = op_rd ? {rbyte, lo_q} : Result_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_io_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      lo_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_io_q    <= mem_io_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bus_err_q   <= bus_err_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
    end
  end

  mem_wb_latch u_wb (
    .CLK (CLK),
    .RST (RST),
    .ld  (wb_ld),
    .d   (wb_nxt),
    .q   (wb_out)
  );

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_io      = mem_io_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign bus_err     = bus_err_q;
  assign Wr_id_out   = wb_out.wr_id;
  assign Wr_data_out = wb_out.data;
  assign Fmask_out   = wb_out.fmask;
  assign Flags_out   = wb_out.flags;
  assign EOI_out     = wb_out.eoi;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of single-cycle non-memory bundles,
// hand sequences for bus corner cases, and random transactions checked
// against a transaction-level model of the expected bus cycles and result.
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  Wr_id_in;
  logic [7:0]  Fmask_in;
  logic [6:0]  MEMctrl_in;
  logic [7:0]  Flags_in;
  logic [15:0] Result_in;
  logic [15:0] Src1_in;
  logic [15:0] seqNPC_in;
  logic        EOI_in;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        stall, mem_req, mem_we, mem_io, bus_err, EOI_out;
  logic [15:0] mem_addr, Wr_data_out;
  logic [7:0]  mem_wdata, Fmask_out, Flags_out;
  logic [4:0]  Wr_id_out;

  int errors = 0;
  int checks = 0;

  mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .Wr_id_in(Wr_id_in), .Fmask_in(Fmask_in), .MEMctrl_in(MEMctrl_in),
    .Flags_in(Flags_in), .Result_in(Result_in), .Src1_in(Src1_in),
    .seqNPC_in(seqNPC_in), .EOI_in(EOI_in),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .bus_err(bus_err),
    .Wr_id_out(Wr_id_out), .Wr_data_out(Wr_data_out), .Fmask_out(Fmask_out),
    .Flags_out(Flags_out), .EOI_out(EOI_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  wr_id;
    logic [7:0]  fmask;
    logic [7:0]  flags;
    logic [6:0]  mc;
    logic [15:0] res;
    logic [15:0] src1;
    logic [15:0] npc;
    logic        eoi;
  } bnd_t;

  typedef struct {
    bnd_t        b;
    logic        ack;
    logic [4:0]  e_id;
    logic [15:0] e_data;
    logic [7:0]  e_fmask;
    logic [7:0]  e_flags;
    logic        e_eoi;
  } vec_t;

  function automatic bnd_t mkb(input logic [4:0] id, input logic [7:0] fm, input logic [7:0] fl,
                               input logic [6:0] mc, input logic [15:0] res, input logic [15:0] src,
                               input logic [15:0] npc, input logic eoi);
    bnd_t b;
    b.wr_id = id; b.fmask = fm; b.flags = fl; b.mc = mc;
    b.res = res; b.src1 = src; b.npc = npc; b.eoi = eoi;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bnd_t b);
    Wr_id_in = b.wr_id; Fmask_in = b.fmask; Flags_in = b.flags; MEMctrl_in = b.mc;
    Result_in = b.res; Src1_in = b.src1; seqNPC_in = b.npc; EOI_in = b.eoi;
  endtask

  task automatic chk_wb(input string tag, input logic [4:0] id, input logic [15:0] data,
                        input logic [7:0] fm, input logic [7:0] fl, input logic eoi);
    chk({tag, "_wr_id"}, 32'(Wr_id_out), 32'(id));
    chk({tag, "_wr_data"}, 32'(Wr_data_out), 32'(data));
    chk({tag, "_fmask"}, 32'(Fmask_out), 32'(fm));
    chk({tag, "_flags"}, 32'(Flags_out), 32'(fl));
    chk({tag, "_eoi"}, 32'(EOI_out), 32'(eoi));
  endtask

  // One complete transaction. dN is the cycle (0-based within the byte's
  // request) on which the slave acks; dN >= TMO means never ack.
  task automatic run_txn(input string tag, input bnd_t b, input int d0, input int d1,
                         input logic [7:0] r0, input logic [7:0] r1, input logic spur);
    logic        rd, wr, io, word, sel;
    logic [7:0]  got [2];
    logic [15:0] exp_data, ea;
    logic [7:0]  ewd;
    logic        t0, timed, eerr;
    int          nb, d, lim, stall_cnt, exp_stall;
    rd = b.mc[0]; wr = b.mc[1]; io = b.mc[2]; word = b.mc[3]; sel = b.mc[4];
    drive(b);
    mem_ack = spur;          // no request yet: must be ignored
    mem_rdata = 8'h00;
    #1;
    if (!(rd | wr)) begin
      chk({tag, "_stall_nomem"}, 32'(stall), 32'd0);
      tick();
      mem_ack = 1'b0;
      chk_wb({tag, "_nomem"}, b.wr_id, sel ? b.npc : b.res, b.fmask, b.flags, b.eoi);
      return;
    end
    stall_cnt = 32'(stall);
    exp_stall = 1;
    tick();
    mem_ack = 1'b0;
    nb = word ? 2 : 1;
    t0 = 1'b0;
    timed = 1'b0;
    for (int bi = 0; bi < nb; bi++) begin
      d     = (bi == 0) ? d0 : d1;
      timed = (d >= TMO);
      lim   = timed ? TMO - 1 : d;
      ea    = b.res + 16'(bi);
      ewd   = (bi == 0) ? b.src1[7:0] : b.src1[15:8];
      exp_stall += lim + 1;
      for (int k = 0; k <= lim; k++) begin
        eerr = (bi == 1 && k == 0) ? t0 : 1'b0;
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, "_we"}, 32'(mem_we), 32'(wr & ~rd));
        chk({tag, "_io"}, 32'(mem_io), 32'(io));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(ewd));
        chk({tag, "_bus_err_acc"}, 32'(bus_err), 32'(eerr));
        chk({tag, "_wb_bubble_acc"}, 32'(Wr_id_out), 32'd0);
        stall_cnt += 32'(stall);
        if (k == lim && !timed) begin
          mem_ack = 1'b1;
          mem_rdata = (bi == 0) ? r0 : r1;
        end
        tick();
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
      end
      got[bi] = timed ? 8'hFF : ((bi == 0) ? r0 : r1);
      if (bi == 0) t0 = timed;
    end
    if (rd)        exp_data = word ? {got[1], got[0]} : {8'h00, got[0]};
    else           exp_data = b.res;
    // DONE cycle
    chk({tag, "_req_done"}, 32'(mem_req), 32'd0);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_bus_err_done"}, 32'(bus_err), 32'(timed));
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    chk_wb({tag, "_done"}, b.wr_id, exp_data, b.fmask, b.flags, b.eoi);
    mem_ack = spur;          // stray ack after the access: ignored
    tick();
    mem_ack = 1'b0;
    chk_wb({tag, "_post"}, 5'd0, 16'd0, 8'd0, 8'd0, 1'b0);
    chk({tag, "_req_post"}, 32'(mem_req), 32'd0);
    chk({tag, "_bus_err_post"}, 32'(bus_err), 32'd0);
  endtask

  vec_t vecs [5];
  bnd_t zb;

  initial begin
    zb = mkb(5'd0, 8'd0, 8'd0, 7'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    vecs[0] = '{mkb(5'd3,  8'h00, 8'h00, 7'h00, 16'h1234, 16'h0000, 16'h0000, 1'b0), 1'b0, 5'd3,  16'h1234, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{mkb(5'd31, 8'hA5, 8'h3C, 7'h10, 16'h1111, 16'h2222, 16'h0104, 1'b1), 1'b1, 5'd31, 16'h0104, 8'hA5, 8'h3C, 1'b1};
    vecs[2] = '{mkb(5'd0,  8'h00, 8'h00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0), 1'b1, 5'd0,  16'h0000, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{mkb(5'd7,  8'h01, 8'h80, 7'h64, 16'hCAFE, 16'h9999, 16'h0055, 1'b0), 1'b0, 5'd7,  16'hCAFE, 8'h01, 8'h80, 1'b0};
    vecs[4] = '{mkb(5'd0,  8'hFF, 8'h00, 7'h78, 16'h0000, 16'h4321, 16'hFFFF, 1'b1), 1'b1, 5'd0,  16'hFFFF, 8'hFF, 8'h00, 1'b1};

    RST = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
    drive(zb);
    repeat (3) tick();
    RST = 1'b0;
    #1;
    // Reset state
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_io", 32'(mem_io), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk_wb("rst", 5'd0, 16'd0, 8'd0, 8'd0, 1'b0);

    // Non-memop table: one-cycle latency, stall stays low, acks ignored
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].b);
      mem_ack = vecs[i].ack;
      mem_rdata = 8'h77;
      #1;
      chk("vec_stall", 32'(stall), 32'd0);
      tick();
      mem_ack = 1'b0;
      chk_wb("vec", vecs[i].e_id, vecs[i].e_data, vecs[i].e_fmask, vecs[i].e_flags, vecs[i].e_eoi);
      chk("vec_req", 32'(mem_req), 32'd0);
    end

    // Byte load, ack on the 2nd request cycle
    run_txn("ld_byte", mkb(5'd4, 8'h0F, 8'h11, 7'h01, 16'h8000, 16'h0000, 16'h0000, 1'b0), 1, 0, 8'h5A, 8'h00, 1'b0);
    // Word store across the address wrap, immediate acks
    run_txn("st_word", mkb(5'd0, 8'h00, 8'h00, 7'h0A, 16'hFFFF, 16'hBEEF, 16'h0000, 1'b1), 0, 0, 8'h00, 8'h00, 1'b1);
    // Byte load timing out
    run_txn("tmo_byte", mkb(5'd9, 8'h00, 8'h00, 7'h01, 16'h0040, 16'h0000, 16'h0000, 1'b0), TMO, 0, 8'h00, 8'h00, 1'b0);
    // rd and wr both set with io: read from I/O space
    run_txn("rdwr_io", mkb(5'd2, 8'h33, 8'h44, 7'h07, 16'h00F0, 16'h1357, 16'h0000, 1'b0), 2, 0, 8'hC3, 8'h00, 1'b0);
    // Word load: lo times out, hi acks
    run_txn("ld_word_tmo", mkb(5'd5, 8'h00, 8'h01, 7'h09, 16'h1000, 16'h0000, 16'h0000, 1'b0), TMO, 1, 8'h00, 8'h6B, 1'b0);

    // Reset in ACC_HI
    drive(mkb(5'd6, 8'h12, 8'h34, 7'h09, 16'h2000, 16'h0000, 16'h0000, 1'b1));
    #1;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'hAA;
    tick();
    mem_ack = 1'b0;
    chk("rsthi_req_before", 32'(mem_req), 32'd1);
    chk("rsthi_addr_before", 32'(mem_addr), 32'h2001);
    RST = 1'b1;
    drive(zb);
    tick();
    RST = 1'b0;
    #1;
    chk("rsthi_req", 32'(mem_req), 32'd0);
    chk("rsthi_stall", 32'(stall), 32'd0);
    chk_wb("rsthi", 5'd0, 16'd0, 8'd0, 8'd0, 1'b0);
    drive(mkb(5'd8, 8'h01, 8'h02, 7'h00, 16'hABCD, 16'h0000, 16'h0000, 1'b0));
    #1;
    chk("rsthi_idle_stall", 32'(stall), 32'd0);
    tick();
    chk_wb("rsthi_idle", 5'd8, 16'hABCD, 8'h01, 8'h02, 1'b0);

    // Random transactions
    for (int n = 0; n < 60; n++) begin
      bnd_t rb;
      int   rd0, rd1;
      rb = mkb(5'($urandom), 8'($urandom), 8'($urandom), 7'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) rb.res = 16'hFFFF;
      rd0 = $urandom_range(0, TMO + 1);
      rd1 = $urandom_range(0, TMO + 1);
      run_txn("rnd", rb, rd0, rd1, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
